// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised pipeline register stage with a valid/ready handshake, flush,
// and a 2-entry skid buffer. The skid buffer lets in_ready be driven only
// from state flops, with no combinational path from out_ready, while still
// sustaining one item per cycle. Whenever no payload is presented, out_data
// shows a configurable NOP pattern.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   flush      synchronous squash of every held entry (highest priority)
//   in_valid   upstream presents in_data
//   in_ready   stage can accept (decoded from state flops only)
//   in_data    upstream payload, WIDTH bits
//   out_valid  stage presents out_data
//   out_ready  downstream accepts
//   out_data   payload, forced to NOP_VALUE while out_valid = 0
//   occupancy  number of entries held (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned      WIDTH     = 64,
    parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // The state encoding is {main valid, skid valid}. The skid register can
    // only be valid while the main register is valid, so 2'b01 is unused.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] m_data_q;
    logic [WIDTH-1:0] m_data_d;
    logic [WIDTH-1:0] s_data_q;
    logic             m_load;
    logic             m_from_skid;
    logic             s_load;
    logic             m_valid;
    logic             s_valid;
    logic             push;
    logic             pop;

    assign m_valid = (state_q != EMPTY);
    assign s_valid = (state_q == FULL);

    assign in_ready  = ~s_valid;
    assign out_valid = m_valid;
    assign out_data  = m_valid ? m_data_q : NOP_VALUE;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

    assign push = in_valid & in_ready;
    assign pop  = m_valid & out_ready;

    // Next-state and register-load enables. Flush overrides every transfer.
    // Any pop still completes from the downstream point of view, because the
    // downstream samples the pre-edge out_data.
    always_comb begin
        state_d     = state_q;
        m_load      = 1'b0;
        m_from_skid = 1'b0;
        s_load      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        m_load  = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        m_load = 1'b1;
                    end else if (push) begin
                        state_d = FULL;
                        s_load  = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so in_valid cannot push. The skid
                    // entry always drains into main, which keeps strict FIFO
                    // order.
                    if (pop) begin
                        state_d     = ONE;
                        m_load      = 1'b1;
                        m_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    assign m_data_d = m_from_skid ? s_data_q : in_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // The data registers are loaded only on their enables. Stalled data
    // therefore never toggles, and a flush leaves stale data that the
    // out_data mux hides.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data_q <= NOP_VALUE;
        end else if (m_load) begin
            m_data_q <= m_data_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_data_q <= NOP_VALUE;
        end else if (s_load) begin
            s_data_q <= in_data;
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline register stage replacing the fixed-width, free-running inter-stage registers between IF/ID/EX/MEM/WB.
- Adds a valid/ready handshake, stall back-pressure and flush.
- A 2-entry skid buffer keeps full throughput while in_ready is registered, so no combinational ready path crosses stages.
- Bubbles present a configurable NOP payload downstream.

Parameters:
- WIDTH, 64, payload bits per stage (e.g. 64 IF/ID, 178 ID/EX, 155 EX/MEM, 117 MEM/WB).
- NOP_VALUE, {WIDTH{1'b0}}, payload driven on out_data whenever out_valid=0, and reset value of all data registers.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous squash of all held entries (branch mispredict / exception)
- in_valid  input  1  upstream presents payload
- in_ready  output  1  stage can accept; registered, no combinational path from out_ready
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  stage presents payload
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  payload; equals NOP_VALUE when out_valid=0
- occupancy  output  2  entries held (0..2)

Behaviour:
- Storage: main register M (drives outputs) and skid register S, each with a valid bit.
- Transfer rules: push = in_valid & in_ready; pop = out_valid & out_ready.
- Outputs:
  - out_valid = M.valid.
  - out_data = M.valid ? M.data : NOP_VALUE.
  - in_ready = ~S.valid.
  - occupancy = M.valid + S.valid.
- Reset (async, asserted): M.valid=S.valid=0; M.data=S.data=NOP_VALUE. Outputs: out_valid=0, out_data=NOP_VALUE, in_ready=1, occupancy=0. Release is synchronous to clk; first push is accepted on the first rising edge after deassertion.
- States (encoded by valid bits):
  - EMPTY (M0,S0):
    - push -> ONE, M<=in_data.
    - otherwise stay.
  - ONE (M1,S0):
    - push&pop -> ONE, M<=in_data.
    - push&~pop -> FULL, S<=in_data.
    - pop&~push -> EMPTY.
    - neither -> hold.
  - FULL (M1,S1), in_ready=0:
    - pop -> ONE, M<=S.data, S.valid<=0.
    - otherwise hold.
    - in_valid is ignored.
- Latency: 1 cycle in->out when EMPTY or ONE with pop. Steady-state throughput is 1 item/cycle with out_ready held high.
- Ordering: strict FIFO; S is never bypassed by in_data.
- flush (synchronous, highest priority):
  - Next edge gives M.valid=S.valid=0, i.e. EMPTY.
  - Any push or pop on that edge is discarded. The downstream still samples the pre-edge out_data if out_ready=1, so the pop is counted as completed.
  - in_data offered on the flush cycle is dropped.
  - Data registers need not be cleared; masking to NOP_VALUE is guaranteed by the out_data mux.
- out_data must be stable while out_valid=1 & out_ready=0.
- Reset asserted mid-transfer overrides flush and any handshake immediately (asynchronous).
- Data registers load only on their enable, so holding stalled data consumes no switching power.

Test Plan:
- Reset then stream 0x1..0x8 with in_valid=1, out_ready=1 -> out_data=0x1 one cycle after the first push, then one item per cycle; in_ready stays 1; occupancy=1.
- Push 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0 on the following cycle. Third item 0xC is held off. Raise out_ready -> outputs 0xA, 0xB, 0xC in order with no loss or duplication.
- FULL with out_ready=1 and in_valid=1 on the same edge -> pop 0xA, M<=0xB, in_ready returns to 1 next cycle, occupancy=1.
- FULL holding 0xA, 0xB, assert flush with in_valid=1, in_data=0xC -> next cycle out_valid=0, out_data=NOP_VALUE (0 default, and 0x00000013 with WIDTH=32 and NOP_VALUE=0x13), occupancy=0, in_ready=1; 0xC never appears.
- Assert reset asynchronously mid-stream, between clock edges -> out_valid=0, out_data=NOP_VALUE and in_ready=1 immediately before the next edge; stream restarts cleanly after release.
- Randomised in_valid/out_ready at 50% for 10k cycles, scoreboard vs reference FIFO -> zero mismatches; occupancy never exceeds 2; out_data never changes while out_valid=1 & out_ready=0.
